seq_shift_unit: RTL and testbench

Multi-cycle shift unit for the 16-bit ALU datapath. It accepts an operand, a shift amount and a shift op through a valid/ready handshake. It then applies one single-bit shift per clock to an internal working register, using the same one-bit left/right step as the ALU's combinational shift stage. When the count is done it presents the result, carry and zero flags downstream until they are accepted.

---
 rtl/seq_shift_unit.sv | 116 +++++++++++
 tb/tb_seq_shift_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift unit: accepts an operand over valid/ready, applies one single-bit
// shift or rotate per clock, then holds result, carry and zero flag until accepted.
module seq_shift_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;
  localparam logic [1:0] OpRol = 2'b11;

  localparam logic [AMT_W-1:0] CntOne = AMT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [1:0]       op_q, op_d;
  logic             carry_q, carry_d;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    count_d = count_q;
    op_d    = op_q;
    carry_d = carry_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          work_d  = in_data;
          count_d = in_amt;
          op_d    = in_op;
          carry_d = 1'b0;
          state_d = (in_amt == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        // SHIFT is only entered with a nonzero count; the guard keeps it from wrapping.
        if (count_q != '0) begin
          count_d = count_q - CntOne;
        end
        unique case (op_q)
          OpSll: begin
            work_d  = {work_q[WIDTH-2:0], 1'b0};
            carry_d = work_q[WIDTH-1];
          end
          OpSrl: begin
            work_d  = {1'b0, work_q[WIDTH-1:1]};
            carry_d = work_q[0];
          end
          OpSra: begin
            work_d  = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            carry_d = work_q[0];
          end
          OpRol: begin
            work_d  = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            carry_d = work_q[WIDTH-1];
          end
          default: ;
        endcase
        if (count_q == CntOne) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      work_q  <= '0;
      count_q <= '0;
      op_q    <= 2'b00;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      count_q <= count_d;
      op_q    <= op_d;
      carry_q <= carry_d;
    end
  end

  // Result outputs read as zero outside DONE so downstream never sees partial work.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    out_data  = out_valid ? work_q : '0;
    out_carry = out_valid & carry_q;
    out_zero  = out_valid & (work_q == '0);
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: directed vectors, random ops against an
// arithmetic reference model, backpressure and mid-operation reset.
module tb_seq_shift_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_amt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_carry;
  logic        out_zero;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_shift_unit #(.WIDTH(16), .AMT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  // Reference: whole-shift arithmetic; carry is the last bit to leave the word.
  function automatic void model(input logic [1:0] op, input logic [15:0] data,
                                input logic [3:0] amt, output logic [15:0] res,
                                output logic carry);
    logic [31:0]        w;
    logic signed [15:0] s;
    logic signed [15:0] t;
    w = {16'h0, data};
    s = data;
    res = data;
    carry = 1'b0;
    case (op)
      2'b00: begin
        w = w << amt;
        res = w[15:0];
        carry = (amt != 0) ? w[16] : 1'b0;
      end
      2'b01: begin
        res = data >> amt;
        w = {16'h0, data} >> ((amt == 0) ? 0 : amt - 1);
        carry = (amt != 0) ? w[0] : 1'b0;
      end
      2'b10: begin
        t = s >>> amt;
        res = t;
        t = s >>> ((amt == 0) ? 0 : amt - 1);
        carry = (amt != 0) ? t[0] : 1'b0;
      end
      default: begin
        w = ({16'h0, data} << amt) | ({16'h0, data} >> (16 - amt));
        res = w[15:0];
        carry = (amt != 0) ? res[0] : 1'b0;
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request with out_ready high and returns what the DUT produced.
  task automatic run_op(input logic [1:0] op, input logic [15:0] data, input logic [3:0] amt,
                        output logic [15:0] rd, output logic rc, output logic rz,
                        output int lat, output logic busy_seen, output logic rdy_after);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    in_valid = 1'b1;
    in_op = op;
    in_data = data;
    in_amt = amt;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    busy_seen = busy;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    rd = out_data;
    rc = out_carry;
    rz = out_zero;
    tick();
    rdy_after = in_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    in_amt = '0;
    in_op = '0;
    tick();
    tick();
    rst = 1'b0;
    tests++;
    if ({in_ready, out_valid, out_data, out_carry, out_zero, busy} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
      fails++;
      $display("FAIL reset_state got rdy=%b vld=%b data=%h c=%b z=%b busy=%b exp 1 0 0000 0 0 0",
               in_ready, out_valid, out_data, out_carry, out_zero, busy);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  ops  [7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00};
    logic [15:0] dat  [7] = '{16'h0001, 16'h8001, 16'h8000, 16'h8001, 16'h1234, 16'h1234, 16'h8000};
    logic [3:0]  amts [7] = '{4'd4, 4'd1, 4'd15, 4'd1, 4'd0, 4'd0, 4'd1};
    logic [15:0] exd  [7] = '{16'h0010, 16'h4000, 16'hFFFF, 16'h0003, 16'h1234, 16'h1234, 16'h0000};
    logic        exc  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] rd;
    logic        rc, rz, bs, ra;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], dat[i], amts[i], rd, rc, rz, lat, bs, ra);
      tests++;
      if ({rd, rc, rz} !== {exd[i], exc[i], exd[i] == 16'h0}) begin
        fails++;
        $display("FAIL directed_%0d got data=%h c=%b z=%b exp data=%h c=%b z=%b",
                 i, rd, rc, rz, exd[i], exc[i], exd[i] == 16'h0);
      end
      tests++;
      if (lat !== amts[i] + 1) begin
        fails++;
        $display("FAIL directed_latency_%0d got %0d exp %0d", i, lat, amts[i] + 1);
      end
      tests++;
      if (bs !== 1'b1 || ra !== 1'b1) begin
        fails++;
        $display("FAIL directed_busy_ready_%0d got busy=%b rdy_after=%b exp 1 1", i, bs, ra);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [15:0] data, rd, er;
    logic [3:0]  amt;
    logic        rc, rz, bs, ra, ec;
    int          lat;
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      data = 16'($urandom);
      if (i % 10 == 0) data = 16'h0;
      amt = 4'($urandom_range(0, 15));
      model(op, data, amt, er, ec);
      run_op(op, data, amt, rd, rc, rz, lat, bs, ra);
      tests++;
      if ({rd, rc, rz, lat, ra} !== {er, ec, er == 16'h0, int'(amt) + 1, 1'b1}) begin
        fails++;
        $display("FAIL random_%0d op=%0d in=%h amt=%0d got %h c=%b z=%b lat=%0d rdy=%b exp %h c=%b z=%b lat=%0d rdy=1",
                 i, op, data, amt, rd, rc, rz, lat, ra, er, ec, er == 16'h0, amt + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    int          guard;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_op = 2'b00;
    in_data = 16'h0001;
    in_amt = 4'd2;
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 40) begin
      tick();
      guard++;
    end
    held = out_data;
    tests++;
    if (held !== 16'h0004) begin
      fails++;
      $display("FAIL bp_result got %h exp 0004", held);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 16'h5A5A + 16'(i);
      in_amt = 4'd3;
      in_op = 2'b11;
      tests++;
      if ({out_valid, out_data, in_ready, busy} !== {1'b1, held, 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL bp_hold_%0d got vld=%b data=%h rdy=%b busy=%b exp 1 %h 0 1",
                 i, out_valid, out_data, in_ready, busy, held);
      end
      tick();
    end
    in_data = 16'hABCD;
    in_amt = 4'd0;
    in_op = 2'b01;
    out_ready = 1'b1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_no_same_cycle_accept got rdy=%b exp 0", in_ready);
    end
    tick();
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL bp_after_handshake got rdy=%b vld=%b exp 1 0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if ({out_valid, out_data, out_carry} !== {1'b1, 16'hABCD, 1'b0}) begin
      fails++;
      $display("FAIL bp_new_request got vld=%b data=%h c=%b exp 1 abcd 0",
               out_valid, out_data, out_carry);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_op = 2'b00;
    in_data = 16'h0003;
    in_amt = 4'd10;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({in_ready, out_valid, busy, out_data} !== {3'b100, 16'h0}) begin
      fails++;
      $display("FAIL reset_mid_state got rdy=%b vld=%b busy=%b data=%h exp 1 0 0 0000",
               in_ready, out_valid, busy, out_data);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen++;
      tick();
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL reset_mid_no_output got %0d valid cycles exp 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
